ahb_dma_write_master: RTL and testbench

AHB_DMA_WRITE_MASTER -- requirements
Module: ahb_dma_write_master

---
 rtl/ahb_dma_write_master_if.sv | 36 +++
 rtl/ahb_dma_write_master.sv | 170 +++++++++++++++++
 tb/tb_ahb_dma_write_master.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dma_write_master_if.sv
// Bus bundle for the AHB DMA write master: command handshake, status pulses
// and the AHB-Lite master signals.
//   master modport : the DMA engine (drives cmd_ready, done, err and the H* outputs)
//   slave  modport : the command source / AHB slave side (drives cmd_*, busy_req, HREADY, HRESP)
interface ahb_dma_write_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              busy_req;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HBURST;
  logic [2:0]        HSIZE;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_data, busy_req, HREADY, HRESP,
    output cmd_ready, done, err, HADDR, HWDATA, HWRITE, HTRANS, HBURST, HSIZE
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_data, busy_req, HREADY, HRESP,
    input  cmd_ready, done, err, HADDR, HWDATA, HWRITE, HTRANS, HBURST, HSIZE
  );
endinterface

// File: rtl/ahb_dma_write_master.sv
// AHB-Lite DMA write master: accepts a (start address, beat count, seed data)
// command and writes an incrementing burst whose data is seed + beat index.
// Address and data phases are pipelined; HREADY=0 freezes the bus outputs.
// Ports:
//   HCLK    : clock, rising edge
//   HRESETn : synchronous active-low reset
//   bus     : ahb_dma_write_master_if.master (command handshake, done/err, AHB signals)
// Build option: define AHB_DMA_BUSY_INSERT_EN to honour busy_req (BUSY cycles
// inside INCR bursts); otherwise busy_req is ignored.
module ahb_dma_write_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb_dma_write_master_if.master bus
);
  localparam int unsigned BYTES      = DATA_W / 8;
  localparam logic [2:0]  HSIZE_BEAT = (DATA_W == 64) ? 3'b011 : 3'b010;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [2:0] HB_INCR4  = 3'b011;
  localparam logic [2:0] HB_INCR8  = 3'b101;
  localparam logic [2:0] HB_INCR16 = 3'b111;

  typedef enum logic [2:0] {IDLE, NSEQ, BURST, LAST, ABORT} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] haddr_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              hwrite_q;
  logic [1:0]        htrans_q;
  logic [2:0]        hburst_q;
  logic [2:0]        hsize_q;
  logic              cmd_ready_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q;   // data of the beat currently in its address phase
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;   // index of the beat currently in its address phase

  logic              err_ph_c;
  logic              busy_ins_c;
  logic [LEN_W-1:0]  last_beat_c;

  // Burst encoding is fixed for the whole transfer from the commanded length.
  function automatic logic [2:0] burst_of(input logic [LEN_W-1:0] len);
    if (len == LEN_W'(1))       return HB_SINGLE;
    else if (len == LEN_W'(4))  return HB_INCR4;
    else if (len == LEN_W'(8))  return HB_INCR8;
    else if (len == LEN_W'(16)) return HB_INCR16;
    else                        return HB_INCR;
  endfunction

  // First cycle of a two-cycle ERROR response.
  assign err_ph_c    = bus.HRESP && !bus.HREADY;
  assign last_beat_c = len_q - LEN_W'(1);

`ifdef AHB_DMA_BUSY_INSERT_EN
  assign busy_ins_c = bus.busy_req && (hburst_q == HB_INCR);
`else
  logic unused_busy_req_c;
  assign unused_busy_req_c = bus.busy_req;
  assign busy_ins_c        = 1'b0;
`endif

  // Transfer FSM with registered bus outputs; everything advances only on HREADY.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      hwrite_q    <= 1'b0;
      htrans_q    <= TR_IDLE;
      hburst_q    <= HB_SINGLE;
      hsize_q     <= 3'b010;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hsize_q <= HSIZE_BEAT;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= NSEQ;
              cmd_ready_q <= 1'b0;
              hwrite_q    <= 1'b1;
              htrans_q    <= TR_NONSEQ;
              haddr_q     <= bus.cmd_addr;
              hburst_q    <= burst_of(bus.cmd_len);
              data_q      <= bus.cmd_data;
              len_q       <= bus.cmd_len;
              beat_q      <= '0;
            end
          end
        end
        NSEQ, BURST: begin
          if (err_ph_c) begin
            state_q  <= ABORT;
            htrans_q <= TR_IDLE;
          end else if (bus.HREADY) begin
            if (htrans_q == TR_BUSY) begin
              // BUSY carries no data phase: keep the pending address, counters idle.
              htrans_q <= busy_ins_c ? TR_BUSY : TR_SEQ;
            end else begin
              hwdata_q <= data_q;
              data_q   <= data_q + DATA_W'(1);
              if (beat_q == last_beat_c) begin
                state_q  <= LAST;
                htrans_q <= TR_IDLE;
              end else begin
                state_q  <= BURST;
                beat_q   <= beat_q + LEN_W'(1);
                haddr_q  <= haddr_q + ADDR_W'(BYTES);
                htrans_q <= (state_q == BURST && busy_ins_c) ? TR_BUSY : TR_SEQ;
              end
            end
          end
        end
        LAST: begin
          if (err_ph_c) begin
            state_q <= ABORT;
          end else if (bus.HREADY) begin
            state_q     <= IDLE;
            hwrite_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            if (bus.HRESP) err_q  <= 1'b1;
            else           done_q <= 1'b1;
          end
        end
        ABORT: begin
          htrans_q <= TR_IDLE;
          if (bus.HREADY) begin
            state_q     <= IDLE;
            hwrite_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            err_q       <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.HADDR     = haddr_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HBURST    = hburst_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ahb_dma_write_master.sv
// Directed self-checking bench for ahb_dma_write_master (32-bit address/data).
module tb_ahb_dma_write_master;
  logic HCLK;
  logic HRESETn;
  int   n_vec = 0;
  int   n_err = 0;

  ahb_dma_write_master_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(6)) bus ();

  ahb_dma_write_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(6)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Outputs are registered: sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input int len, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_len   = 6'(len);
    bus.cmd_data  = data;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Full transfer; HREADY is low for n cycles starting at cycle s (cycle 0 = NONSEQ).
  // Expected outputs: beat index k shown in cycle c, frozen during the stall.
  task automatic xfer(input string nm, input logic [31:0] addr, input int len,
                      input logic [31:0] data, input logic [2:0] burst,
                      input int s, input int n);
    int k;
    issue(addr, len, data);
    chk({nm, ".cmd_ready_busy"}, 64'(bus.cmd_ready), 64'd0);
    for (int c = 0; c <= len + n + 1; c++) begin
      if (c <= s)          k = c;
      else if (c <= s + n) k = s;
      else                 k = c - n;
      if (c == len + n + 1) begin
        chk($sformatf("%s.c%0d.done", nm, c), 64'(bus.done), 64'd1);
        chk($sformatf("%s.c%0d.cmd_ready", nm, c), 64'(bus.cmd_ready), 64'd1);
        chk($sformatf("%s.c%0d.hwrite", nm, c), 64'(bus.HWRITE), 64'd0);
      end else begin
        chk($sformatf("%s.c%0d.done", nm, c), 64'(bus.done), 64'd0);
        chk($sformatf("%s.c%0d.hwrite", nm, c), 64'(bus.HWRITE), 64'd1);
        if (k < len) begin
          chk($sformatf("%s.c%0d.htrans", nm, c), 64'(bus.HTRANS), (k == 0) ? 64'd2 : 64'd3);
          chk($sformatf("%s.c%0d.haddr", nm, c), 64'(bus.HADDR), 64'(32'(addr + 32'(k) * 32'd4)));
          chk($sformatf("%s.c%0d.hburst", nm, c), 64'(bus.HBURST), 64'(burst));
        end else begin
          chk($sformatf("%s.c%0d.htrans", nm, c), 64'(bus.HTRANS), 64'd0);
        end
        if (k >= 1)
          chk($sformatf("%s.c%0d.hwdata", nm, c), 64'(bus.HWDATA), 64'(32'(data + 32'(k - 1))));
      end
      bus.HREADY = (c >= s && c < s + n) ? 1'b0 : 1'b1;
      step();
    end
    chk({nm, ".done_once"}, 64'(bus.done), 64'd0);
    bus.HREADY = 1'b1;
  endtask

  // BUSY scenario, hand-written per cycle: len=5 at 0x2000, seed 0x10,
  // busy_req high during cycles 1 and 2.
`ifdef AHB_DMA_BUSY_INSERT_EN
  localparam int BT_N = 9;
  logic [1:0]  bt_tr [BT_N] = '{2'd2, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [31:0] bt_ad [BT_N] = '{32'h2000, 32'h2004, 32'h2008, 32'h2008, 32'h2008,
                                32'h200C, 32'h2010, 32'h0, 32'h0};
  logic [31:0] bt_wd [BT_N] = '{32'h0, 32'h10, 32'h11, 32'h11, 32'h11, 32'h12, 32'h13,
                                32'h14, 32'h0};
`else
  localparam int BT_N = 7;
  logic [1:0]  bt_tr [BT_N] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [31:0] bt_ad [BT_N] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010,
                                32'h0, 32'h0};
  logic [31:0] bt_wd [BT_N] = '{32'h0, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h0};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.busy_req  = 1'b0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    step();
    step();

    // Reset values
    chk("rst.htrans", 64'(bus.HTRANS), 64'd0);
    chk("rst.haddr", 64'(bus.HADDR), 64'd0);
    chk("rst.hwdata", 64'(bus.HWDATA), 64'd0);
    chk("rst.hwrite", 64'(bus.HWRITE), 64'd0);
    chk("rst.hburst", 64'(bus.HBURST), 64'd0);
    chk("rst.hsize", 64'(bus.HSIZE), 64'd2);
    chk("rst.cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.err", 64'(bus.err), 64'd0);
    HRESETn = 1'b1;
    step();
    chk("rel.cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Zero-length command: done next cycle, no bus activity
    issue(32'h0000_0040, 0, 32'h5);
    chk("len0.done", 64'(bus.done), 64'd1);
    chk("len0.htrans", 64'(bus.HTRANS), 64'd0);
    chk("len0.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    step();
    chk("len0.done_off", 64'(bus.done), 64'd0);

    xfer("incr4", 32'h1000, 4, 32'hA0, 3'b011, 99, 0);
    chk("incr4.hsize", 64'(bus.HSIZE), 64'd2);
    xfer("single", 32'h1100, 1, 32'h33, 3'b000, 99, 0);
    xfer("incr6", 32'h0100, 6, 32'h7, 3'b001, 99, 0);
    xfer("incr8_wait", 32'h1800, 8, 32'hB0, 3'b101, 2, 3);
    xfer("wrap", 32'hFFFF_FFF8, 4, 32'hFFFF_FFFE, 3'b011, 99, 0);
    xfer("max63", 32'h8000, 63, 32'h1, 3'b001, 10, 2);

    // BUSY insertion (or its absence when the option is not built)
    issue(32'h2000, 5, 32'h10);
    for (int c = 0; c < BT_N; c++) begin
      chk($sformatf("busy.c%0d.htrans", c), 64'(bus.HTRANS), 64'(bt_tr[c]));
      if (bt_tr[c] != 2'd0) begin
        chk($sformatf("busy.c%0d.haddr", c), 64'(bus.HADDR), 64'(bt_ad[c]));
        chk($sformatf("busy.c%0d.hburst", c), 64'(bus.HBURST), 64'd1);
      end
      if (c >= 1 && c < BT_N - 1)
        chk($sformatf("busy.c%0d.hwdata", c), 64'(bus.HWDATA), 64'(bt_wd[c]));
      chk($sformatf("busy.c%0d.done", c), 64'(bus.done), (c == BT_N - 1) ? 64'd1 : 64'd0);
      bus.busy_req = (c == 1 || c == 2) ? 1'b1 : 1'b0;
      step();
    end
    bus.busy_req = 1'b0;

    // ERROR on the data phase of beat 2 of an INCR8
    issue(32'h3000, 8, 32'h50);
    chk("err.c0.htrans", 64'(bus.HTRANS), 64'd2);
    step();
    step();
    step();
    chk("err.c3.htrans", 64'(bus.HTRANS), 64'd3);
    chk("err.c3.haddr", 64'(bus.HADDR), 64'h300C);
    chk("err.c3.hwdata", 64'(bus.HWDATA), 64'h52);
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    step();
    chk("err.c4.htrans", 64'(bus.HTRANS), 64'd0);
    chk("err.c4.err", 64'(bus.err), 64'd0);
    bus.HREADY = 1'b1;
    step();
    chk("err.c5.err", 64'(bus.err), 64'd1);
    chk("err.c5.done", 64'(bus.done), 64'd0);
    chk("err.c5.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("err.c5.htrans", 64'(bus.HTRANS), 64'd0);
    bus.HRESP = 1'b0;
    step();
    chk("err.c6.err", 64'(bus.err), 64'd0);
    chk("err.c6.done", 64'(bus.done), 64'd0);

    // Reset during beat 3 of an INCR16
    issue(32'h4000, 16, 32'h70);
    step();
    step();
    step();
    chk("mrst.c3.hburst", 64'(bus.HBURST), 64'd7);
    chk("mrst.c3.haddr", 64'(bus.HADDR), 64'h400C);
    HRESETn = 1'b0;
    step();
    chk("mrst.htrans", 64'(bus.HTRANS), 64'd0);
    chk("mrst.haddr", 64'(bus.HADDR), 64'd0);
    chk("mrst.hwdata", 64'(bus.HWDATA), 64'd0);
    chk("mrst.hwrite", 64'(bus.HWRITE), 64'd0);
    chk("mrst.hburst", 64'(bus.HBURST), 64'd0);
    chk("mrst.hsize", 64'(bus.HSIZE), 64'd2);
    chk("mrst.cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("mrst.done", 64'(bus.done), 64'd0);
    chk("mrst.err", 64'(bus.err), 64'd0);
    HRESETn = 1'b1;
    step();
    chk("mrst.rel.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("mrst.rel.done", 64'(bus.done), 64'd0);
    chk("mrst.rel.err", 64'(bus.err), 64'd0);
    xfer("after_rst", 32'h5000, 4, 32'hC0, 3'b011, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
